// File: rtl/hex_display_arbiter.sv
// Two-requester round-robin arbiter for a six-digit seven-segment display.
// A winner's 24-bit value is latched on the IDLE decision edge, acked for one
// cycle in GRANT, then held on the display for DWELL_CYCLES cycles in HOLD.
// Requests arriving during GRANT/HOLD are not latched; they are seen again
// in the next IDLE cycle.
//
// state | meaning
// IDLE  | waiting for any request; arbitration happens on the next edge
// GRANT | winner's ack is high for this single cycle; display shows new data
// HOLD  | dwell period of exactly DWELL_CYCLES cycles, requests ignored
`timescale 1ns/1ps
module hex_display_arbiter #(
  parameter int unsigned DWELL_CYCLES = 1000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        req_a,
  input  logic [23:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [23:0] data_b,
  output logic        ack_b,
  output logic [20:0] hex0_2_export,
  output logic [20:0] hex3_5_export,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Last HOLD count value; counter runs 0..DWELL_CYCLES-1.
  localparam logic [19:0] HOLD_LAST = 20'(DWELL_CYCLES - 1);

  state_t      state;
  logic [19:0] hold_cnt;
  logic [23:0] disp_data;
  logic        last_b;

  // Active-low hex decode, bit0 = segment a .. bit6 = segment g.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Arbitration FSM, dwell counter and registered display/owner/ack outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      hold_cnt  <= 20'd0;
      disp_data <= 24'd0;
      owner     <= 2'b00;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      last_b    <= 1'b1;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            // A wins when alone, or on a tie when B was granted last.
            if (req_a && (!req_b || last_b)) begin
              ack_a     <= 1'b1;
              owner     <= 2'b01;
              disp_data <= data_a;
              last_b    <= 1'b0;
            end else begin
              ack_b     <= 1'b1;
              owner     <= 2'b10;
              disp_data <= data_b;
              last_b    <= 1'b1;
            end
            state <= GRANT;
          end
        end
        GRANT: begin
          hold_cnt <= 20'd0;
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 20'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Segment decode straight from registered nibbles; blank until first grant.
  always_comb begin
    hex0_2_export = '1;
    hex3_5_export = '1;
    if (owner != 2'b00) begin
      hex0_2_export = {seg7(disp_data[11:8]),  seg7(disp_data[7:4]),   seg7(disp_data[3:0])};
      hex3_5_export = {seg7(disp_data[23:20]), seg7(disp_data[19:16]), seg7(disp_data[15:12])};
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench for hex_display_arbiter: directed vectors push expected
// grants into a queue, a negedge monitor pops and compares on every ack.
`timescale 1ns/1ps
module tb_hex_display_arbiter;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [23:0] data_a = 24'd0, data_b = 24'd0;
  logic        ack_a, ack_b;
  logic [20:0] hex0_2, hex3_5;
  logic [1:0]  owner;

  hex_display_arbiter #(.DWELL_CYCLES(D)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .hex0_2_export(hex0_2), .hex3_5_export(hex3_5), .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  src;
    logic [23:0] data;
    int          at;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  bit rand_mode = 1'b0;
  bit acked_a = 1'b0, acked_b = 1'b0;
  logic [23:0] last_data = 24'd0;
  logic [1:0]  last_src = 2'b00;
  int          last_ack_cyc = -100;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [20:0] lo(input logic [23:0] d);
    return {seg(d[11:8]), seg(d[7:4]), seg(d[3:0])};
  endfunction

  function automatic logic [20:0] hi(input logic [23:0] d);
    return {seg(d[23:20]), seg(d[19:16]), seg(d[15:12])};
  endfunction

  // Monitor: compares each ack against the scoreboard (or the live stimulus
  // data during random traffic) and checks display retention between acks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack_a || ack_b) begin
        logic [1:0]  src;
        logic [23:0] ed;
        src = ack_a ? 2'b01 : 2'b10;
        ed  = ack_a ? data_a : data_b;
        check("ack_exclusive", 64'(ack_a & ack_b), 64'd0);
        if (rand_mode) begin
          check("ack_spacing", 64'(cyc - last_ack_cyc >= D + 2), 64'd1);
          if (ack_a) acked_a = 1'b1;
          if (ack_b) acked_b = 1'b1;
        end else if (q.size() == 0) begin
          check("unexpected_ack", 64'(src), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("ack_source", 64'(src), 64'(e.src));
          check("ack_cycle", 64'(cyc), 64'(e.at));
          ed = e.data;
        end
        check("grant_owner", 64'(owner), 64'(src));
        check("grant_hex0_2", 64'(hex0_2), 64'(lo(ed)));
        check("grant_hex3_5", 64'(hex3_5), 64'(hi(ed)));
        last_data    = ed;
        last_src     = src;
        last_ack_cyc = cyc;
      end else if (rand_mode) begin
        check("retain_owner", 64'(owner), 64'(last_src));
        check("retain_hex0_2", 64'(hex0_2), 64'(lo(last_data)));
        check("retain_hex3_5", 64'(hex3_5), 64'(hi(last_data)));
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [23:0] d, input int at);
    exp_t e;
    e.src = s; e.data = d; e.at = at;
    q.push_back(e);
  endtask

  task automatic wait_ack(input string nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_a || ack_b) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no ack within 40 cycles, expected one", nm);
  endtask

  task automatic check_blank(input string nm);
    check({nm, "_ack_a"}, 64'(ack_a), 64'd0);
    check({nm, "_ack_b"}, 64'(ack_b), 64'd0);
    check({nm, "_owner"}, 64'(owner), 64'd0);
    check({nm, "_hex0_2"}, 64'(hex0_2), 64'h1FFFFF);
    check({nm, "_hex3_5"}, 64'(hex3_5), 64'h1FFFFF);
  endtask

  initial begin
    int g;
    // reset state
    repeat (3) @(negedge clk);
    check_blank("reset");
    drive_edge();
    rst_n = 1'b1;

    // single request from A, first grant after reset
    drive_edge();
    req_a = 1'b1; data_a = 24'h012345;
    push(2'b01, 24'h012345, cyc + 1);
    wait_ack("single_a");
    drive_edge();
    req_a = 1'b0;
    repeat (10) @(negedge clk);
    check("retain_owner_a", 64'(owner), 64'd1);
    check("retain_hex0_2_a", 64'(hex0_2), 64'({7'h30, 7'h19, 7'h12}));
    check("retain_hex3_5_a", 64'(hex3_5), 64'({7'h40, 7'h79, 7'h24}));

    // reset so the tie pointer starts at B, then hold both requests
    drive_edge();
    rst_n = 1'b0;
    repeat (2) drive_edge();
    rst_n = 1'b1;
    drive_edge();
    req_a = 1'b1; data_a = 24'hFEDCBA;
    req_b = 1'b1; data_b = 24'h987654;
    push(2'b01, 24'hFEDCBA, cyc + 1);
    push(2'b10, 24'h987654, cyc + 1 + (D + 2));
    push(2'b01, 24'hFEDCBA, cyc + 1 + 2 * (D + 2));
    wait_ack("tie_1");
    wait_ack("tie_2");
    wait_ack("tie_3");
    drive_edge();
    req_a = 1'b0; req_b = 1'b0;
    repeat (8) drive_edge();

    // B arrives during A's HOLD and must wait for the next IDLE
    req_a = 1'b1; data_a = 24'h111111;
    push(2'b01, 24'h111111, cyc + 1);
    wait_ack("hold_a");
    g = cyc;
    drive_edge();
    req_a = 1'b0;
    drive_edge();
    req_b = 1'b1; data_b = 24'hABCDEF;
    push(2'b10, 24'hABCDEF, g + D + 2);
    @(negedge clk);
    check("hold_no_ack_b", 64'(ack_b), 64'd0);
    check("hold_owner", 64'(owner), 64'd1);
    check("hold_hex0_2", 64'(hex0_2), 64'(lo(24'h111111)));
    wait_ack("late_b");
    drive_edge();
    req_b = 1'b0;
    repeat (8) drive_edge();

    // reset two cycles into HOLD aborts everything; B then wins at once
    req_a = 1'b1; data_a = 24'h0F0F0F;
    push(2'b01, 24'h0F0F0F, cyc + 1);
    wait_ack("pre_reset_a");
    drive_edge();
    req_a = 1'b0; req_b = 1'b1; data_b = 24'h2468AC;
    drive_edge();
    rst_n = 1'b0;
    #1;
    check_blank("mid_hold_reset");
    repeat (2) drive_edge();
    rst_n = 1'b1;
    push(2'b10, 24'h2468AC, cyc + 1);
    wait_ack("post_reset_b");
    drive_edge();
    req_b = 1'b0;
    repeat (8) drive_edge();

    // random traffic; requesters hold data stable until acked
    rand_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      drive_edge();
      if (acked_a) begin
        acked_a = 1'b0;
        req_a   = 1'($urandom_range(1, 0));
        data_a  = 24'($urandom);
      end else if (!req_a && $urandom_range(3, 0) == 0) begin
        req_a  = 1'b1;
        data_a = 24'($urandom);
      end
      if (acked_b) begin
        acked_b = 1'b0;
        req_b   = 1'($urandom_range(1, 0));
        data_b  = 24'($urandom);
      end else if (!req_b && $urandom_range(3, 0) == 0) begin
        req_b  = 1'b1;
        data_b = 24'($urandom);
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    repeat (D + 4) drive_edge();
    rand_mode = 1'b0;
    check("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
